// File: rtl/tone_request_scheduler.sv
// Round-robin scheduler sharing one square-wave tone generator between NUM_REQ requesters.
// Each grant latches a note and a duration, plays it for dur ticks, then inserts a silent gap.
module tone_request_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NOTE_W    = 17,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NOTE_W-1:0]    req_note,
  input  logic [NUM_REQ*DUR_W-1:0]     req_dur,
  input  logic                         stop,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         done,
  output logic [$clog2(NUM_REQ)-1:0]   active_id,
  output logic [NOTE_W-1:0]            note_out,
  output logic                         tone_rst,
  output logic                         busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        state;
  logic [ID_W-1:0]   rr;
  logic [TICK_W-1:0] tick_cnt;
  logic [DUR_W-1:0]  dur_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tick;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic [NOTE_W-1:0] pick_note;
  logic [DUR_W-1:0]  pick_dur;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]   rr_next;

  assign tick = (tick_cnt == TICK_LAST);

  // Handshake: req[i] is a level held by the requester until it sees the one-cycle ack[i];
  // req/req_note/req_dur are sampled only while IDLE, so later changes never affect a tone in flight.
  always_comb begin
    pick_valid  = 1'b0;
    pick_id     = '0;
    pick_note   = '0;
    pick_dur    = '0;
    pick_onehot = '0;
    // Walk distances from farthest to nearest so the requester closest to rr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (((int'(rr) + k) % NUM_REQ) == i)) begin
          pick_valid  = 1'b1;
          pick_id     = ID_W'(i);
          pick_note   = req_note[i*NOTE_W +: NOTE_W];
          pick_dur    = req_dur[i*DUR_W +: DUR_W];
          pick_onehot = '0;
          pick_onehot[i] = 1'b1;
        end
      end
    end
  end

  assign rr_next = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ack       <= '0;
      done      <= 1'b0;
      active_id <= '0;
      note_out  <= '0;
      tone_rst  <= 1'b1;
      busy      <= 1'b0;
      rr        <= '0;
      tick_cnt  <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      if (stop) begin
        state    <= S_IDLE;
        tone_rst <= 1'b1;
        busy     <= 1'b0;
        tick_cnt <= '0;
        dur_cnt  <= '0;
        gap_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pick_valid) begin
              ack       <= pick_onehot;
              active_id <= pick_id;
              note_out  <= pick_note;
              dur_cnt   <= pick_dur;
              tick_cnt  <= '0;
              rr        <= rr_next;
              state     <= S_PLAY;
              busy      <= 1'b1;
              // A zero-length tone never releases the generator.
              tone_rst  <= (pick_dur == '0);
            end
          end
          S_PLAY: begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            if ((dur_cnt == '0) || (tick && (dur_cnt == DUR_W'(1)))) begin
              tone_rst <= 1'b1;
              done     <= 1'b1;
              tick_cnt <= '0;
              dur_cnt  <= '0;
              gap_cnt  <= '0;
              if (GAP_TICKS == 0) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_GAP;
              end
            end else if (tick) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end
          end
          S_GAP: begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            if (tick) begin
              if (gap_cnt == GAP_LAST) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                gap_cnt <= '0;
              end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
              end
            end
          end
          default: begin
            state    <= S_IDLE;
            tone_rst <= 1'b1;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_request_scheduler.sv
// Bench for tone_request_scheduler: directed scenarios then random traffic, every cycle
// compared against a timeline model of grant/done/idle edges.
module tb_tone_request_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int NOTE_W    = 17;
  localparam int DUR_W     = 8;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int ID_W      = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*NOTE_W-1:0] req_note;
  logic [NUM_REQ*DUR_W-1:0]  req_dur;
  logic                      stop;
  logic [NUM_REQ-1:0]        ack;
  logic                      done;
  logic [ID_W-1:0]           active_id;
  logic [NOTE_W-1:0]         note_out;
  logic                      tone_rst;
  logic                      busy;

  tone_request_scheduler #(
    .NUM_REQ(NUM_REQ), .NOTE_W(NOTE_W), .DUR_W(DUR_W),
    .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_note(req_note), .req_dur(req_dur),
    .stop(stop), .ack(ack), .done(done), .active_id(active_id),
    .note_out(note_out), .tone_rst(tone_rst), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  // Timeline model: edges (cycle numbers) of the current transaction.
  longint m_g = -1;        // grant edge
  longint m_d = -1;        // done edge (-1 = none)
  longint m_low_end = -1;  // first edge at which tone_rst is high again
  longint m_i = -1;        // edge after which the scheduler is idle
  int     m_id = 0;
  int     m_rr = 0;
  logic [NOTE_W-1:0] m_note = '0;

  // scoreboard
  logic [ID_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: event did not occur within bound (cycle %0d)", tag, cyc);
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    onehot_idx = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (v[i]) onehot_idx = i;
  endfunction

  task automatic model_edge(input longint e);
    int id;
    int dur;
    if (rst) begin
      m_g = -1; m_d = -1; m_low_end = -1; m_i = -1;
      m_id = 0; m_rr = 0; m_note = '0;
      exp_q.delete();
    end else if (stop) begin
      if (e <= m_d) m_d = -1;
      if (e < m_low_end) m_low_end = e;
      if (e < m_i) m_i = e;
    end else if ((e - 1 >= m_i) && (req != '0)) begin
      id = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (m_rr + k) % NUM_REQ;
        if (id < 0 && req[c]) id = c;
      end
      dur    = int'(req_dur[id*DUR_W +: DUR_W]);
      m_note = req_note[id*NOTE_W +: NOTE_W];
      m_id   = id;
      m_rr   = (id + 1) % NUM_REQ;
      m_g    = e;
      if (dur != 0) begin
        m_low_end = e + longint'(dur) * TICK_DIV;
        m_d       = m_low_end;
      end else begin
        m_low_end = e;
        m_d       = e + 1;
      end
      m_i = m_d + GAP_TICKS * TICK_DIV;
      exp_q.push_back(ID_W'(id));
    end
  endtask

  // One clock: update the model with the inputs about to be sampled, then compare.
  task automatic step();
    logic [NUM_REQ-1:0] e_ack;
    logic [ID_W-1:0] e_id;
    model_edge(cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
    e_ack = '0;
    if (cyc == m_g) e_ack[m_id] = 1'b1;
    check("ack", 32'(ack), 32'(e_ack));
    check("done", 32'(done), 32'(cyc == m_d));
    check("active_id", 32'(active_id), 32'(m_id));
    check("note_out", 32'(note_out), 32'(m_note));
    check("tone_rst", 32'(tone_rst), 32'(!(m_g >= 0 && cyc >= m_g && cyc < m_low_end)));
    check("busy", 32'(busy), 32'(m_g >= 0 && cyc >= m_g && cyc < m_i));
    if (ack != '0) begin
      if (exp_q.size() > 0) begin
        e_id = exp_q.pop_front();
        check("sb_ack_id", 32'(onehot_idx(ack)), 32'(e_id));
      end else begin
        fail_now("sb_unexpected_ack");
      end
    end
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic [NOTE_W-1:0] note, input logic [DUR_W-1:0] dur);
    req_note[i*NOTE_W +: NOTE_W] = note;
    req_dur[i*DUR_W +: DUR_W]    = dur;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  // Holds req=mask until one requester is acked, then drops only that bit.
  task automatic request_until_ack(input logic [NUM_REQ-1:0] mask, output int id);
    req = mask;
    id  = -1;
    for (int k = 0; k < 60 && id < 0; k++) begin
      step();
      if (ack != '0) id = onehot_idx(ack);
    end
    if (id < 0) fail_now("ack_timeout");
    else req = req & ~ack;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      step();
      if (!busy) ok = 1'b1;
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  initial begin
    int id, id2, id3, low_cnt, done_cnt, silent_cnt, busy_cnt, n_acks;
    int ack_ids[8];
    longint ack_cyc[8];

    rst = 1'b1; stop = 1'b0; req = '0; req_note = '0; req_dur = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 17'($urandom), 8'd1);
    do_reset(3);

    // Reset values
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_tone_rst", 32'(tone_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_note", 32'(note_out), 32'd0);

    // Single tone: note 100, three ticks
    set_req(0, 17'd100, 8'd3);
    request_until_ack(4'b0001, id);
    check("t1_id", 32'(id), 32'd0);
    check("t1_note", 32'(note_out), 32'd100);
    low_cnt = (tone_rst == 1'b0) ? 1 : 0;
    done_cnt = 0; silent_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (!tone_rst) low_cnt++;
      if (done) done_cnt++;
      if (busy && tone_rst) silent_cnt++;
    end
    check("t1_low_cycles", 32'(low_cnt), 32'd12);
    check("t1_done_pulses", 32'(done_cnt), 32'd1);
    check("t1_silent_cycles", 32'(silent_cnt), 32'd4);
    check("t1_busy_end", 32'(busy), 32'd0);

    // All four held, one-tick tones: rotation and spacing
    do_reset(2);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 17'($urandom), 8'd1);
    req = 4'b1111;
    n_acks = 0;
    for (int k = 0; k < 45; k++) begin
      step();
      if (ack != '0 && n_acks < 8) begin
        ack_ids[n_acks] = onehot_idx(ack);
        ack_cyc[n_acks] = cyc;
        n_acks++;
      end
    end
    req = '0;
    check("t2_num_acks", 32'(n_acks), 32'd5);
    for (int k = 0; k < 5 && k < n_acks; k++) check("t2_order", 32'(ack_ids[k]), 32'(k % 4));
    for (int k = 1; k < 5 && k < n_acks; k++)
      check("t2_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd9);
    wait_idle();

    // Round-robin after a grant of 1
    do_reset(2);
    request_until_ack(4'b0010, id);
    check("t3_first", 32'(id), 32'd1);
    request_until_ack(4'b0101, id2);
    check("t3_second", 32'(id2), 32'd2);
    request_until_ack(req, id3);
    check("t3_third", 32'(id3), 32'd0);
    wait_idle();

    // Zero-length tone on requester 3
    set_req(3, 17'($urandom), 8'd0);
    request_until_ack(4'b1000, id);
    check("t4_id", 32'(id), 32'd3);
    check("t4_tone_rst_at_ack", 32'(tone_rst), 32'd1);
    step();
    check("t4_done_next", 32'(done), 32'd1);
    low_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!tone_rst) low_cnt++;
      if (busy) busy_cnt++;
    end
    check("t4_never_low", 32'(low_cnt), 32'd0);
    check("t4_gap_busy", 32'(busy_cnt), 32'd3);

    // stop five cycles into a three-tick tone
    set_req(2, 17'($urandom), 8'd3);
    request_until_ack(4'b0100, id);
    check("t5_id", 32'(id), 32'd2);
    repeat (4) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t5_tone_rst", 32'(tone_rst), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) done_cnt++;
    end
    check("t5_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 17'($urandom), 8'd1);
    request_until_ack(4'b1111, id);
    check("t5_rr_next", 32'(id), 32'd3);
    req = '0;
    wait_idle();

    // rst in the middle of a tone
    set_req(0, 17'($urandom), 8'd3);
    request_until_ack(4'b0001, id);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_ack", 32'(ack), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_active_id", 32'(active_id), 32'd0);
    check("t6_note", 32'(note_out), 32'd0);
    check("t6_tone_rst", 32'(tone_rst), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    request_until_ack(4'b1010, id);
    check("t6_grant", 32'(id), 32'd1);
    req = '0;
    wait_idle();

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      set_req($urandom_range(0, 3), 17'($urandom), 8'($urandom_range(0, 3)));
      stop = ($urandom_range(0, 29) == 0);
      rst  = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; stop = 1'b0; req = '0;
    wait_idle();
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
